// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port, 1-cycle-read-latency word memory between two
//   strobe-bus masters (m0 = CPU, m1 = secondary master such as a loader/DMA).
//   An uncontended request is forwarded combinationally to s_*, so it sees the
//   same timing as a direct memory connection. A request that loses
//   arbitration is parked in a one-deep per-master slot; the master sees busy
//   until the parked request has been issued.
//
// Parameters
//   ADDR_W      address width of masters and slave port
//   PRIO_FIXED  0 = round-robin on contention, 1 = m0 always wins contention
//
// Ports
//   clk, resetn                    clock (rising edge), async active-low reset
//   mN_addr/wdata/wmask/rstrb      master N request (wmask!=0 -> write, rstrb -> read)
//   mN_rdata, mN_rvalid            master N read return (rvalid pulses with data)
//   mN_busy                        master N slot occupied, no new request allowed
//   s_addr/wdata/wmask/rstrb       memory request
//   s_rdata                        memory read data, valid the cycle after s_rstrb
//   proto_err                      sticky: a master requested while busy
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int PRIO_FIXED = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wmask,
  input  logic              m0_rstrb,
  output logic [31:0]       m0_rdata,
  output logic              m0_rvalid,
  output logic              m0_busy,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wmask,
  input  logic              m1_rstrb,
  output logic [31:0]       m1_rdata,
  output logic              m1_rvalid,
  output logic              m1_busy,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wmask,
  output logic              s_rstrb,
  input  logic [31:0]       s_rdata,
  output logic              proto_err
);

  logic              m0_req, m1_req;

  logic              slot0_vld, slot1_vld;
  logic [ADDR_W-1:0] slot0_addr, slot1_addr;
  logic [31:0]       slot0_wdata, slot1_wdata;
  logic [3:0]        slot0_wmask, slot1_wmask;
  logic              slot0_rstrb, slot1_rstrb;

  logic              c0_vld, c1_vld;
  logic [ADDR_W-1:0] c0_addr, c1_addr;
  logic [31:0]       c0_wdata, c1_wdata;
  logic [3:0]        c0_wmask, c1_wmask;
  logic              c0_rstrb, c1_rstrb;

  logic              gnt0, gnt1;
  logic              last_grant;   // 1 = master 1 was granted last
  logic              rd_pending;
  logic              rd_owner;     // 1 = pending read belongs to master 1
  logic [31:0]       hold0, hold1;

  assign m0_req = m0_rstrb | (|m0_wmask);
  assign m1_req = m1_rstrb | (|m1_wmask);

  // A parked request always takes precedence over the live inputs; a live
  // request arriving while the slot is full is a protocol error and dropped.
  always_comb begin
    c0_vld   = slot0_vld | m0_req;
    c0_addr  = slot0_vld ? slot0_addr  : m0_addr;
    c0_wdata = slot0_vld ? slot0_wdata : m0_wdata;
    c0_wmask = slot0_vld ? slot0_wmask : m0_wmask;
    c0_rstrb = slot0_vld ? slot0_rstrb : m0_rstrb;
    c1_vld   = slot1_vld | m1_req;
    c1_addr  = slot1_vld ? slot1_addr  : m1_addr;
    c1_wdata = slot1_vld ? slot1_wdata : m1_wdata;
    c1_wmask = slot1_vld ? slot1_wmask : m1_wmask;
    c1_rstrb = slot1_vld ? slot1_rstrb : m1_rstrb;
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (c0_vld && c1_vld) begin
      // On a tie the master that was not granted last wins (round-robin).
      if ((PRIO_FIXED != 0) || last_grant) gnt0 = 1'b1;
      else                                 gnt1 = 1'b1;
    end else begin
      gnt0 = c0_vld;
      gnt1 = c1_vld;
    end
  end

  always_comb begin
    s_addr  = m0_addr;
    s_wdata = m0_wdata;
    s_wmask = 4'b0000;
    s_rstrb = 1'b0;
    if (gnt0) begin
      s_addr  = c0_addr;
      s_wdata = c0_wdata;
      s_wmask = c0_wmask;
      s_rstrb = c0_rstrb;
    end else if (gnt1) begin
      s_addr  = c1_addr;
      s_wdata = c1_wdata;
      s_wmask = c1_wmask;
      s_rstrb = c1_rstrb;
    end
    // Keep the memory quiet while reset is held, even with live inputs.
    if (!resetn) begin
      s_wmask = 4'b0000;
      s_rstrb = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot0_vld   <= 1'b0;
      slot0_addr  <= '0;
      slot0_wdata <= '0;
      slot0_wmask <= '0;
      slot0_rstrb <= 1'b0;
      slot1_vld   <= 1'b0;
      slot1_addr  <= '0;
      slot1_wdata <= '0;
      slot1_wmask <= '0;
      slot1_rstrb <= 1'b0;
      last_grant  <= 1'b1;
      rd_pending  <= 1'b0;
      rd_owner    <= 1'b0;
      hold0       <= '0;
      hold1       <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (gnt0 || gnt1) begin
        last_grant <= gnt1;
        rd_owner   <= gnt1;
      end
      rd_pending <= (gnt0 & c0_rstrb) | (gnt1 & c1_rstrb);

      if (rd_pending) begin
        if (rd_owner) hold1 <= s_rdata;
        else          hold0 <= s_rdata;
      end

      if (slot0_vld) begin
        if (gnt0) slot0_vld <= 1'b0;
      end else if (m0_req && !gnt0) begin
        slot0_vld   <= 1'b1;
        slot0_addr  <= m0_addr;
        slot0_wdata <= m0_wdata;
        slot0_wmask <= m0_wmask;
        slot0_rstrb <= m0_rstrb;
      end

      if (slot1_vld) begin
        if (gnt1) slot1_vld <= 1'b0;
      end else if (m1_req && !gnt1) begin
        slot1_vld   <= 1'b1;
        slot1_addr  <= m1_addr;
        slot1_wdata <= m1_wdata;
        slot1_wmask <= m1_wmask;
        slot1_rstrb <= m1_rstrb;
      end

      if ((slot0_vld && m0_req) || (slot1_vld && m1_req)) proto_err <= 1'b1;
    end
  end

  assign m0_busy   = slot0_vld;
  assign m1_busy   = slot1_vld;
  assign m0_rvalid = rd_pending & ~rd_owner;
  assign m1_rvalid = rd_pending &  rd_owner;
  // Returned data bypasses straight through; otherwise the last read is held.
  assign m0_rdata  = m0_rvalid ? s_rdata : hold0;
  assign m1_rdata  = m1_rvalid ? s_rdata : hold1;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Drives a round-robin instance (index 0) and a fixed-priority instance
//   (index 1) with the same master stimulus. Each instance has its own small
//   behavioural memory. A transaction-level model predicts every output each
//   cycle; directed sequences add explicit checks on top.
module tb_mem_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
  } txn_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_clr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_rstrb, m1_rstrb;

  logic [31:0] m0_rdata [2];
  logic [31:0] m1_rdata [2];
  logic        m0_rvalid [2];
  logic        m1_rvalid [2];
  logic        m0_busy [2];
  logic        m1_busy [2];
  logic [31:0] s_addr [2];
  logic [31:0] s_wdata [2];
  logic [3:0]  s_wmask [2];
  logic        s_rstrb [2];
  logic [31:0] s_rdata [2];
  logic        proto_err [2];

  logic [31:0] mem [2][16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .PRIO_FIXED(0)) dut_rr (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata[0]), .m0_rvalid(m0_rvalid[0]), .m0_busy(m0_busy[0]),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata[0]), .m1_rvalid(m1_rvalid[0]), .m1_busy(m1_busy[0]),
    .s_addr(s_addr[0]), .s_wdata(s_wdata[0]), .s_wmask(s_wmask[0]), .s_rstrb(s_rstrb[0]),
    .s_rdata(s_rdata[0]), .proto_err(proto_err[0])
  );

  mem_arbiter #(.ADDR_W(32), .PRIO_FIXED(1)) dut_fx (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata[1]), .m0_rvalid(m0_rvalid[1]), .m0_busy(m0_busy[1]),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata[1]), .m1_rvalid(m1_rvalid[1]), .m1_busy(m1_busy[1]),
    .s_addr(s_addr[1]), .s_wdata(s_wdata[1]), .s_wmask(s_wmask[1]), .s_rstrb(s_rstrb[1]),
    .s_rdata(s_rdata[1]), .proto_err(proto_err[1])
  );

  // 16-word memories, read returns the pre-write word one cycle later.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_clr) begin
        for (int i = 0; i < 16; i++) mem[d][i] <= '0;
        s_rdata[d] <= '0;
      end else begin
        if (s_rstrb[d]) s_rdata[d] <= mem[d][s_addr[d][5:2]];
        for (int b = 0; b < 4; b++)
          if (s_wmask[d][b]) mem[d][s_addr[d][5:2]][8*b +: 8] <= s_wdata[d][8*b +: 8];
      end
    end
  end

  // ---------------- reference model ----------------
  bit          slot_v [2][2];
  txn_t        slot_q [2][2];
  int          last_g [2];      // master granted most recently
  bit          rd_v [2];
  int          rd_o [2];
  logic [31:0] rd_d [2];
  logic [31:0] hold_m [2][2];
  bit          perr_m [2];
  logic [31:0] shadow [2][16];
  int          win_m [2];
  txn_t        cand_m [2][2];
  txn_t        live_t [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_req(input txn_t t);
    return t.rstrb || (t.wmask != 4'b0000);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      slot_v[d][0] = 0; slot_v[d][1] = 0;
      last_g[d] = 1;
      rd_v[d] = 0;
      hold_m[d][0] = '0; hold_m[d][1] = '0;
      perr_m[d] = 0;
      win_m[d] = -1;
    end
  endtask

  // Predict and compare all outputs for the inputs currently applied.
  task automatic sample();
    txn_t ex;
    bit   cv [2];
    bit   ev;
    #1;
    if (!resetn) return;
    live_t[0] = {m0_addr, m0_wdata, m0_wmask, m0_rstrb};
    live_t[1] = {m1_addr, m1_wdata, m1_wmask, m1_rstrb};
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 2; n++) begin
        cand_m[d][n] = slot_v[d][n] ? slot_q[d][n] : live_t[n];
        cv[n] = slot_v[d][n] || is_req(live_t[n]);
      end
      if (cv[0] && cv[1]) win_m[d] = (d == 1 || last_g[d] == 1) ? 0 : 1;
      else if (cv[0])     win_m[d] = 0;
      else if (cv[1])     win_m[d] = 1;
      else                win_m[d] = -1;
      if (win_m[d] >= 0) ex = cand_m[d][win_m[d]];
      else               ex = {m0_addr, m0_wdata, 4'b0000, 1'b0};
      chk($sformatf("s_addr[%0d]", d),  s_addr[d],  ex.addr);
      chk($sformatf("s_wdata[%0d]", d), s_wdata[d], ex.wdata);
      chk($sformatf("s_wmask[%0d]", d), {28'd0, s_wmask[d]}, {28'd0, ex.wmask});
      chk($sformatf("s_rstrb[%0d]", d), {31'd0, s_rstrb[d]}, {31'd0, ex.rstrb});
      ev = rd_v[d] && rd_o[d] == 0;
      chk($sformatf("m0_rvalid[%0d]", d), {31'd0, m0_rvalid[d]}, {31'd0, ev});
      chk($sformatf("m0_rdata[%0d]", d), m0_rdata[d], ev ? rd_d[d] : hold_m[d][0]);
      ev = rd_v[d] && rd_o[d] == 1;
      chk($sformatf("m1_rvalid[%0d]", d), {31'd0, m1_rvalid[d]}, {31'd0, ev});
      chk($sformatf("m1_rdata[%0d]", d), m1_rdata[d], ev ? rd_d[d] : hold_m[d][1]);
      chk($sformatf("m0_busy[%0d]", d), {31'd0, m0_busy[d]}, {31'd0, slot_v[d][0]});
      chk($sformatf("m1_busy[%0d]", d), {31'd0, m1_busy[d]}, {31'd0, slot_v[d][1]});
      chk($sformatf("proto_err[%0d]", d), {31'd0, proto_err[d]}, {31'd0, perr_m[d]});
    end
  endtask

  // Clock edge: apply the transaction-level effect of the sampled cycle.
  task automatic advance();
    txn_t t;
    int   w;
    @(posedge clk);
    if (resetn) begin
      for (int d = 0; d < 2; d++) begin
        if (rd_v[d]) hold_m[d][rd_o[d]] = rd_d[d];
        w = win_m[d];
        rd_v[d] = 0;
        if (w >= 0) begin
          t = cand_m[d][w];
          rd_v[d] = t.rstrb;
          rd_o[d] = w;
          if (t.rstrb) rd_d[d] = shadow[d][t.addr[5:2]];
          for (int b = 0; b < 4; b++)
            if (t.wmask[b]) shadow[d][t.addr[5:2]][8*b +: 8] = t.wdata[8*b +: 8];
          last_g[d] = w;
        end
        for (int n = 0; n < 2; n++) begin
          if (slot_v[d][n]) begin
            if (is_req(live_t[n])) perr_m[d] = 1;
            if (w == n) slot_v[d][n] = 0;
          end else if (is_req(live_t[n]) && w != n) begin
            slot_v[d][n] = 1;
            slot_q[d][n] = live_t[n];
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic r0, input logic [31:0] a0, input logic [3:0] wm0,
                       input logic [31:0] wd0, input logic r1, input logic [31:0] a1,
                       input logic [3:0] wm1, input logic [31:0] wd1);
    m0_rstrb = r0; m0_addr = a0; m0_wmask = wm0; m0_wdata = wd0;
    m1_rstrb = r1; m1_addr = a1; m1_wmask = wm1; m1_wdata = wd1;
  endtask

  task automatic idle();
    drive(0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic step_idle(input int n);
    for (int i = 0; i < n; i++) begin
      idle(); sample(); advance();
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int n0, n1, rv0, rv1;
    logic r0, r1;
    logic [3:0] wm0, wm1;

    idle();
    resetn  = 1'b0;
    mem_clr = 1'b1;
    model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) shadow[d][i] = '0;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy0", {31'd0, m0_busy[d]}, 32'd0);
      chk("rst_busy1", {31'd0, m1_busy[d]}, 32'd0);
      chk("rst_rvalid0", {31'd0, m0_rvalid[d]}, 32'd0);
      chk("rst_rdata0", m0_rdata[d], 32'd0);
      chk("rst_perr", {31'd0, proto_err[d]}, 32'd0);
      chk("rst_srstrb", {31'd0, s_rstrb[d]}, 32'd0);
    end
    @(negedge clk);
    resetn  = 1'b1;
    mem_clr = 1'b0;

    // Solo write then solo read of 0x10.
    drive(0, 32'h10, 4'hF, 32'hDEADBEEF, 0, 32'h0, 4'h0, 32'h0);
    sample(); advance();
    drive(1, 32'h10, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    sample();
    chk("solo_srstrb", {31'd0, s_rstrb[0]}, 32'd1);
    chk("solo_busy", {31'd0, m0_busy[0]}, 32'd0);
    advance();
    idle(); sample();
    chk("solo_rvalid", {31'd0, m0_rvalid[0]}, 32'd1);
    chk("solo_rdata", m0_rdata[0], 32'hDEADBEEF);
    chk("solo_busy2", {31'd0, m0_busy[0]}, 32'd0);
    advance();

    // Tie after reset: m0 read 0x0 vs m1 write 0x4.
    do_reset();
    drive(1, 32'h0, 4'h0, 32'h0, 0, 32'h4, 4'hF, 32'h11223344);
    sample();
    chk("tie_c0_addr", s_addr[0], 32'h0);
    chk("tie_c0_rstrb", {31'd0, s_rstrb[0]}, 32'd1);
    advance();
    idle(); sample();
    chk("tie_c1_busy", {31'd0, m1_busy[0]}, 32'd1);
    chk("tie_c1_addr", s_addr[0], 32'h4);
    chk("tie_c1_wmask", {28'd0, s_wmask[0]}, 32'hF);
    chk("tie_c1_wdata", s_wdata[0], 32'h11223344);
    advance();
    idle(); sample();
    chk("tie_c2_busy", {31'd0, m1_busy[0]}, 32'd0);
    advance();
    drive(0, 32'h0, 4'h0, 32'h0, 1, 32'h4, 4'h0, 32'h0);
    sample(); advance();
    idle(); sample();
    chk("tie_rb_rvalid", {31'd0, m1_rvalid[0]}, 32'd1);
    chk("tie_rb_rdata", m1_rdata[0], 32'h11223344);
    advance();

    // Alternating back-to-back reads, each master honouring busy.
    n0 = 0; n1 = 0; rv0 = 0; rv1 = 0;
    for (int k = 0; k < 6; k++) begin
      r0 = !m0_busy[0];
      r1 = !m1_busy[0];
      n0 += int'(r0);
      n1 += int'(r1);
      drive(r0, 32'h20 + 32'(4*k), 4'h0, 32'h0, r1, 32'h100 + 32'(4*k), 4'h0, 32'h0);
      sample();
      chk("alt_gnt", {31'd0, s_addr[0][8]}, 32'(k % 2));
      rv0 += int'(m0_rvalid[0]);
      rv1 += int'(m1_rvalid[0]);
      advance();
    end
    for (int k = 0; k < 3; k++) begin
      idle(); sample();
      rv0 += int'(m0_rvalid[0]);
      rv1 += int'(m1_rvalid[0]);
      advance();
    end
    chk("alt_reads0", 32'(rv0), 32'(n0));
    chk("alt_reads1", 32'(rv1), 32'(n1));

    // Protocol violation: m1 strobes while busy.
    do_reset();
    drive(1, 32'h8, 4'h0, 32'h0, 1, 32'h144, 4'h0, 32'h0);
    sample();
    chk("viol_first", s_addr[0], 32'h8);
    advance();
    drive(0, 32'h0, 4'h0, 32'h0, 1, 32'h1C8, 4'h0, 32'h0);
    sample();
    chk("viol_busy", {31'd0, m1_busy[0]}, 32'd1);
    chk("viol_issue", s_addr[0], 32'h144);
    advance();
    idle(); sample();
    chk("viol_flag", {31'd0, proto_err[0]}, 32'd1);
    chk("viol_drop", {31'd0, s_rstrb[0]}, 32'd0);
    advance();
    step_idle(3);
    chk("viol_sticky", {31'd0, proto_err[0]}, 32'd1);

    // Fixed priority: both masters request continuously.
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h30 + 32'(4*k), 4'h0, 32'h0, 1, 32'h180 + 32'(4*k), 4'h0, 32'h0);
      sample();
      chk("fx_m0_wins", {31'd0, s_addr[1][8]}, 32'd0);
      if (k > 0) chk("fx_m1_busy", {31'd0, m1_busy[1]}, 32'd1);
      advance();
    end
    idle(); sample();
    chk("fx_m1_addr", s_addr[1], 32'h180);
    chk("fx_m1_rstrb", {31'd0, s_rstrb[1]}, 32'd1);
    advance();
    step_idle(2);

    // Reset the cycle after a read strobe.
    drive(1, 32'h10, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    sample();
    chk("rmr_srstrb", {31'd0, s_rstrb[0]}, 32'd1);
    advance();
    resetn = 1'b0;
    model_reset();
    sample();
    for (int d = 0; d < 2; d++) begin
      chk("rmr_rvalid", {31'd0, m0_rvalid[d]}, 32'd0);
      chk("rmr_rdata", m0_rdata[d], 32'd0);
      chk("rmr_busy1", {31'd0, m1_busy[d]}, 32'd0);
      chk("rmr_perr", {31'd0, proto_err[d]}, 32'd0);
      chk("rmr_srstrb_off", {31'd0, s_rstrb[d]}, 32'd0);
    end
    advance();
    resetn = 1'b1;
    drive(1, 32'h0, 4'h0, 32'h0, 1, 32'h104, 4'h0, 32'h0);
    sample();
    chk("rmr_tie_rr", {31'd0, s_addr[0][8]}, 32'd0);
    chk("rmr_tie_fx", {31'd0, s_addr[1][8]}, 32'd0);
    advance();
    step_idle(2);

    // Randomized traffic; masters honour busy of the round-robin instance.
    for (int k = 0; k < 400; k++) begin
      r0 = 0; wm0 = 4'h0; r1 = 0; wm1 = 4'h0;
      if (!m0_busy[0] && $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 2))
          0: r0 = 1;
          1: wm0 = 4'($urandom_range(1, 15));
          default: begin r0 = 1; wm0 = 4'($urandom_range(1, 15)); end
        endcase
      end
      if (!m1_busy[0] && $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 2))
          0: r1 = 1;
          1: wm1 = 4'($urandom_range(1, 15));
          default: begin r1 = 1; wm1 = 4'($urandom_range(1, 15)); end
        endcase
      end
      drive(r0, $urandom, wm0, $urandom, r1, $urandom, wm1, $urandom);
      sample();
      advance();
    end
    step_idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master arbiter that shares the single-port, 1-cycle-read-latency word memory between the CPU (master 0) and a second bus master (master 1, e.g. UART loader or DMA). Masters use the native strobe bus: addr, rstrb pulse, 4-bit byte wmask, wdata. An uncontended request passes straight through with the same timing as a direct memory connection. A request that loses arbitration is held in a one-deep per-master slot, and the master sees busy until that request is issued.

Parameters:
ADDR_W, 32, address width of masters and slave port
PRIO_FIXED, 0, 0 = round-robin; 1 = master 0 always wins contention

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
m0_addr  in  ADDR_W  master 0 byte address
m0_wdata  in  32  master 0 write data
m0_wmask  in  4  master 0 byte write mask (nonzero = write request)
m0_rstrb  in  1  master 0 read strobe (1-cycle pulse)
m0_rdata  out  32  master 0 read data
m0_rvalid  out  1  pulses high the cycle m0_rdata carries returned data
m0_busy  out  1  master 0 slot occupied; no new request allowed
m1_*  same set as m0_*, for master 1
s_addr  out  ADDR_W  to memory
s_wdata  out  32  to memory
s_wmask  out  4  to memory
s_rstrb  out  1  to memory
s_rdata  in  32  from memory, valid the cycle after s_rstrb
proto_err  out  1  sticky: a master issued a request while busy

Behaviour:
- Request: any cycle with mN_rstrb=1 or |mN_wmask. Read and write in the same cycle are forwarded together as one transaction. The memory returns the pre-write word.
- Candidate N in a cycle: slot_N valid, else the live request of N. Slot contents take precedence over live inputs.
- Grant, combinational, one winner per cycle.
  - Single candidate: it wins.
  - Both candidates, PRIO_FIXED=1: m0 wins.
  - Both candidates, PRIO_FIXED=0: the master not in last_grant wins.
  - last_grant updates on every grant.
- Slave drive: the winner's addr/wdata/wmask/rstrb go to s_* in the same cycle, so an uncontended request has zero added latency. With no winner: s_rstrb=0, s_wmask=0, s_addr/s_wdata = m0 inputs.
- Loser with a live request is captured into slot_N (addr, wdata, wmask, rstrb) at the clock edge. A granted slot clears at the same edge.
- mN_busy = slot_N valid (registered). Round-robin bounds the wait to 1 cycle after capture. Fixed priority gives no bound.
- Read return:
  - rd_pending/rd_owner are registered when the granted transaction has rstrb=1.
  - Next cycle: m{owner}_rvalid=1 and m{owner}_rdata=s_rdata, combinational bypass.
  - hold_{owner} <= s_rdata on that edge.
  - When rvalid=0, mN_rdata = hold_N, so data stays stable until that master's next read.
  - Back-to-back reads from alternating masters each get their own rvalid pulse. There is no bubble between them.
- Protocol violation: a live request from N while slot_N is valid is dropped, the slot keeps its original request, and proto_err is set. proto_err clears only on reset.
- Reset (async, resetn=0): slots invalid, busy=0, rd_pending=0, rvalid=0, hold_N=0, proto_err=0, last_grant=1 (m0 wins the first tie).
  - s_rstrb and s_wmask are forced 0 while resetn=0.
  - A read in flight when reset asserts produces no rvalid.
- Write completion is implicit at grant. There is no write acknowledge.

Test Plan:
- Solo read: m0 rstrb, addr 0x10, memory word 0xDEADBEEF → s_rstrb same cycle, m0_rvalid next cycle with 0xDEADBEEF, m0_busy never 1.
- Tie, round-robin: m0 read 0x0 and m1 write 0x4 (wmask 1111, data 0x11223344) in the same cycle after reset → m0 granted cycle 0. m1_busy=1 in cycle 1, m1 write issued in cycle 1, busy=0 in cycle 2. Read-back of 0x4 returns 0x11223344.
- Alternating back-to-back reads: m0 and m1 strobe every cycle for 6 cycles, each honouring busy → grants alternate 0,1,0,1. Each master's rvalid data matches its address, and no read is lost.
- PRIO_FIXED=1: both masters request continuously → m1_busy stays 1 and s_* always carry m0. m1 is granted the first cycle m0 is idle.
- Violation: m1 strobes again while m1_busy=1 → second request never appears on s_*, proto_err=1 and stays 1 until resetn pulse.
- Reset mid-read: resetn low the cycle after s_rstrb → no rvalid, m0_rdata=0, busy=0, proto_err=0. The first post-reset tie goes to m0.
